// File: rtl/jtag_cmd_driver.sv
// JTAG master: turns RESET / IR-scan / DR-scan commands into TCK/TMS/TDI sequences
// and returns the TDO bits captured during the shift phase.
module jtag_cmd_driver #(
  parameter int TCK_DIV = 20,
  parameter int IR_LEN  = 4
) (
  input  logic        internal_clk,
  input  logic        jtag_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        jtag_clk_out,
  output logic        jtag_mode,
  output logic        jtag_digital_input,
  input  logic        jtag_digital_output
);

  localparam int DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RSP} state_t;

  state_t        state_reg;
  logic [1:0]    op_reg;
  logic [5:0]    len_reg;
  logic [31:0]   data_reg;
  logic [63:0]   tms_plan_reg, tms_plan_next;
  logic [5:0]    steps_reg, steps_next;
  logic [5:0]    first_reg, first_next;
  logic [5:0]    last_reg, last_next;
  logic          shift_en_reg, shift_en_next;
  logic [5:0]    step_reg;
  logic [DW-1:0] div_reg;
  logic          high_reg;

  logic [5:0]    next_step;
  logic          cur_in_shift, next_in_shift;
  logic [4:0]    cur_bit, next_bit;

  // Step plan, bit k of tms_plan is TMS for TCK period k (all start from Run-Test/Idle).
  always_comb begin
    tms_plan_next = 64'h1F;
    steps_next    = 6'd6;
    first_next    = 6'd0;
    last_next     = 6'd0;
    shift_en_next = 1'b0;
    case (op_reg)
      2'd1: begin
        tms_plan_next = 64'h3 | (64'd1 << (IR_LEN + 3)) | (64'd1 << (IR_LEN + 4));
        steps_next    = 6'(IR_LEN + 6);
        first_next    = 6'd4;
        last_next     = 6'(IR_LEN + 3);
        shift_en_next = 1'b1;
      end
      2'd2: begin
        if (len_reg == 6'd0) begin
          tms_plan_next = 64'hD;
          steps_next    = 6'd5;
        end else begin
          tms_plan_next = 64'h1 | (64'd1 << (len_reg + 6'd2)) | (64'd1 << (len_reg + 6'd3));
          steps_next    = len_reg + 6'd5;
          first_next    = 6'd3;
          last_next     = len_reg + 6'd2;
          shift_en_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign next_step     = step_reg + 6'd1;
  assign cur_in_shift  = shift_en_reg && (step_reg >= first_reg) && (step_reg <= last_reg);
  assign next_in_shift = shift_en_reg && (next_step >= first_reg) && (next_step <= last_reg);
  assign cur_bit       = step_reg[4:0] - first_reg[4:0];
  assign next_bit      = next_step[4:0] - first_reg[4:0];

  always_ff @(posedge internal_clk) begin
    if (jtag_rst) begin
      state_reg          <= IDLE;
      cmd_ready          <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_data           <= '0;
      jtag_clk_out       <= 1'b0;
      jtag_mode          <= 1'b1;
      jtag_digital_input <= 1'b0;
      op_reg             <= '0;
      len_reg            <= '0;
      data_reg           <= '0;
      tms_plan_reg       <= '0;
      steps_reg          <= '0;
      first_reg          <= '0;
      last_reg           <= '0;
      shift_en_reg       <= 1'b0;
      step_reg           <= '0;
      div_reg            <= '0;
      high_reg           <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            op_reg    <= cmd_op;
            len_reg   <= (cmd_len > 6'd32) ? 6'd32 : cmd_len;
            data_reg  <= cmd_data;
            cmd_ready <= 1'b0;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          tms_plan_reg       <= tms_plan_next;
          steps_reg          <= steps_next;
          first_reg          <= first_next;
          last_reg           <= last_next;
          shift_en_reg       <= shift_en_next;
          rsp_data           <= '0;
          step_reg           <= '0;
          div_reg            <= '0;
          high_reg           <= 1'b0;
          // Period 0 is never a shift bit and always has TMS=1.
          jtag_mode          <= 1'b1;
          jtag_digital_input <= 1'b0;
          state_reg          <= RUN;
        end
        RUN: begin
          if (div_reg == DW'(TCK_DIV - 1)) begin
            div_reg <= '0;
            if (!high_reg) begin
              jtag_clk_out <= 1'b1;
              high_reg     <= 1'b1;
              if (cur_in_shift) rsp_data[cur_bit] <= jtag_digital_output;
            end else begin
              jtag_clk_out <= 1'b0;
              high_reg     <= 1'b0;
              if (step_reg == steps_reg - 6'd1) begin
                rsp_valid <= 1'b1;
                state_reg <= RSP;
              end else begin
                step_reg           <= next_step;
                jtag_mode          <= tms_plan_reg[next_step];
                jtag_digital_input <= next_in_shift ? data_reg[next_bit] : 1'b0;
              end
            end
          end else begin
            div_reg <= div_reg + DW'(1);
          end
        end
        RSP: begin
          cmd_ready <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_cmd_driver.sv
// Scoreboard bench for jtag_cmd_driver: a per-command model derived from the TMS/TDI
// rules predicts the period sequence and captured TDO; a monitor checks each response.
module tb_jtag_cmd_driver;
  localparam int D   = 20;
  localparam int IRL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [5:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        tck, tms, tdi;
  logic        tdo = 1'b0;

  jtag_cmd_driver #(.TCK_DIV(D), .IR_LEN(IRL)) dut (
    .internal_clk(clk), .jtag_rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .jtag_clk_out(tck), .jtag_mode(tms), .jtag_digital_input(tdi),
    .jtag_digital_output(tdo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          op;
    int          len;
    int          s;
    logic [63:0] tms;
    logic [63:0] tdi;
    logic [63:0] tdo;
    logic [31:0] data;
    logic [31:0] rsp;
    int          hs;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   rc = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: list the TMS bits period by period and note which periods shift data.
  function automatic exp_t model(int op, int len, logic [31:0] data, logic [63:0] tdo_v);
    bit   tms_b[$];
    int   pos[$];
    int   n;
    exp_t e;
    e = '{default: 0};
    n = (len > 32) ? 32 : len;
    if (op == 1) begin
      tms_b.push_back(1); tms_b.push_back(1); tms_b.push_back(0); tms_b.push_back(0);
      for (int i = 0; i < IRL; i++) begin
        pos.push_back(tms_b.size());
        tms_b.push_back(i == IRL - 1);
      end
      tms_b.push_back(1); tms_b.push_back(0);
    end else if (op == 2 && n == 0) begin
      tms_b.push_back(1); tms_b.push_back(0); tms_b.push_back(1);
      tms_b.push_back(1); tms_b.push_back(0);
    end else if (op == 2) begin
      tms_b.push_back(1); tms_b.push_back(0); tms_b.push_back(0);
      for (int i = 0; i < n; i++) begin
        pos.push_back(tms_b.size());
        tms_b.push_back(i == n - 1);
      end
      tms_b.push_back(1); tms_b.push_back(0);
    end else begin
      for (int i = 0; i < 5; i++) tms_b.push_back(1);
      tms_b.push_back(0);
    end
    e.op = op; e.len = len; e.data = data; e.tdo = tdo_v;
    e.s = tms_b.size();
    for (int k = 0; k < e.s; k++) e.tms[k] = tms_b[k];
    for (int i = 0; i < pos.size(); i++) begin
      e.tdi[pos[i]] = data[i];
      e.rsp[i]      = tdo_v[pos[i]];
    end
    return e;
  endfunction

  // Monitor: records TMS/TDI at each TCK rise, drives TDO per period, checks responses.
  initial begin
    logic        tck_q;
    logic [63:0] tms_seen, tdi_seen, mask;
    exp_t        e;
    tck_q = 1'b0; tms_seen = '0; tdi_seen = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rc = 0; tms_seen = '0; tdi_seen = '0;
      end else begin
        if (!tck_q && tck) begin
          if (rc < 64) begin
            tms_seen[rc] = tms;
            tdi_seen[rc] = tdi;
          end
          rc++;
        end
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp_valid", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            mask = (64'd1 << e.s) - 64'd1;
            $display("[TB] op=%0d len=%0d data=%h rsp=%h periods=%0d", e.op, e.len, e.data,
                     rsp_data, rc);
            check("rsp_data", 64'(rsp_data), 64'(e.rsp));
            check("tck_periods", 64'(rc), 64'(e.s));
            check("tms_seq", tms_seen & mask, e.tms);
            check("tdi_seq", tdi_seen & mask, e.tdi);
            // Counted up to the edge that samples rsp_valid high.
            check("latency", 64'(cyc - e.hs + 1), 64'(2 + 2 * e.s * D));
          end
          rc = 0; tms_seen = '0; tdi_seen = '0;
        end
      end
      tck_q = tck;
      tdo = (exp_q.size() > 0 && rc < 64) ? exp_q[0].tdo[rc] : 1'b0;
    end
  end

  task automatic issue(int op, int len, logic [31:0] data, logic [63:0] tdo_v);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", 64'd0, 64'd1);
      return;
    end
    e = model(op, len, data, tdo_v);
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_len = 6'(len); cmd_data = data;
    @(negedge clk);
    e.hs = cyc;
    exp_q.push_back(e);
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_len = 6'($urandom); cmd_data = $urandom;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (exp_q.size() > 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check("completion_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("tck_idle_low", 64'(tck), 64'd0);
  endtask

  initial begin
    logic [63:0] tv;
    int          w;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_tck", 64'(tck), 64'd0);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    rst = 1'b0;

    issue(0, 0, $urandom, {$urandom, $urandom});
    issue(1, 0, 32'hA, {$urandom, $urandom});
    tv = {$urandom, $urandom}; tv[34:3] = 32'hA5C30F96;
    issue(2, 32, $urandom, tv);
    // 1-stage bypass: first shifted-out bit is the captured 0, then TDI delayed by one.
    tv = {$urandom, $urandom}; tv[3] = 1'b0; tv[6:4] = 3'b011;
    issue(2, 4, 32'hB, tv);
    issue(2, 0, $urandom, {$urandom, $urandom});
    issue(2, 40, $urandom, {$urandom, $urandom});
    issue(3, 17, $urandom, {$urandom, $urandom});
    for (int i = 0; i < 12; i++)
      issue($urandom_range(0, 3), $urandom_range(0, 63), $urandom, {$urandom, $urandom});
    wait_idle();

    // Abort a 32-bit DR scan during shift bit 10 (TCK period 13).
    issue(2, 32, $urandom, {$urandom, $urandom});
    w = 0;
    while (!(rc == 13 && !tck) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("abort_reach_bit10", 64'(rc), 64'd13);
    rst = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    check("abort_tck", 64'(tck), 64'd0);
    check("abort_tms", 64'(tms), 64'd1);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(0, 0, $urandom, {$urandom, $urandom});
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jtag_cmd_driver.md
# jtag_cmd_driver

Hardware JTAG master that sits directly upstream of the `jtag` top. It turns single commands into TCK/TMS/TDI bit sequences: test-logic-reset, IR scan or DR scan. During scans it captures TDO and returns the shifted-out word. It replaces the bench-side reset, IR and DR tasks with synthesizable logic, so the TAP can be exercised from on-chip logic running on `internal_clk`.

## Interface
- `TCK_DIV`, 20: `internal_clk` cycles per TCK half-period; legal values ≥2. At 50 MHz this gives an 800 ns TCK.
- `IR_LEN`, 4: instruction register length in bits; 1..32.

Ports:
- `internal_clk` in 1: the only clock.
- `jtag_rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when both valid and ready are high.
- `cmd_op` in 2: 0 = RESET, 1 = IR scan, 2 = DR scan, 3 = reserved (treated as RESET).
- `cmd_len` in 6: DR bit count 0..32; values >32 clamp to 32; ignored for RESET and IR.
- `cmd_data` in 32: TDI bits, shifted LSB first.
- `rsp_valid` out 1: one-cycle pulse at command completion.
- `rsp_data` out 32: captured TDO, LSB = first bit out; bits ≥ length are 0.
- `jtag_clk_out` out 1: TCK, drives `jtag_clk`.
- `jtag_mode` out 1: TMS.
- `jtag_digital_input` out 1: TDI.
- `jtag_digital_output` in 1: TDO from the TAP.

## Operation
- The command is latched on handshake. `cmd_ready` is high only in state IDLE.
- FSM states: IDLE → LOAD → RUN → RSP → IDLE.
  - LOAD (1 cycle): builds the TMS/TDI step plan and the step count S.
  - RUN: emits S TCK periods.
  - RSP: pulses `rsp_valid`.
- TMS per TCK period, starting from Run-Test/Idle:
  - RESET: 1,1,1,1,1,0 (S = 6).
  - IR: 1,1,0,0, then IR_LEN shift bits (TMS=0 on all but the last, 1 on the last), then 1,0 (S = IR_LEN+6).
  - DR, len N ≥ 1: 1,0,0, then N shift bits (last bit TMS=1), then 1,0 (S = N+5).
  - DR, len 0: 1,0,1,1,0 (S = 5). No shift; `rsp_data` = 0.
- TDI = `cmd_data[i]` during shift bit i; otherwise 0.
- TDO is sampled only during shift bits, into `rsp_data[i]`.
- Between commands TCK is stopped and held low. TMS and TDI hold their last values.
- The block tracks no TAP state. Every sequence assumes the TAP starts in Run-Test/Idle; RESET guarantees this.

## Timing
- Each TCK period is 2·TCK_DIV cycles, low half first. A half-period counter runs 0..TCK_DIV-1.
- TMS and TDI for step k update on the same `internal_clk` edge that drives TCK low for period k. They are stable for the full period.
- TDO is sampled on the `internal_clk` edge that drives TCK high, i.e. the TAP's rising edge.
- Latency, handshake to `rsp_valid`: 1 (LOAD) + S·2·TCK_DIV + 1 cycles.
- `rsp_data` is valid with `rsp_valid` and holds until the next LOAD.
- `cmd_ready` returns high the cycle after RSP. A command that is held valid is accepted back-to-back then; the minimum idle gap is 1 cycle.
- A shift bit's TDO sample and the TMS=1 on the last bit belong to the same period. Exit1 is entered on that rising edge.
- Reset values: `cmd_ready`=0 during reset and 1 from the first cycle after. Also `rsp_valid`=0, `rsp_data`=0, `jtag_clk_out`=0, `jtag_mode`=1, `jtag_digital_input`=0. FSM = IDLE, counters = 0.
- Reset mid-command: aborts within one cycle and TCK drops low at once. No `rsp_valid` is produced. Software must issue RESET afterwards.
- `cmd_valid` during RUN is ignored; no queueing.

## Test plan
- RESET command → 6 TCK periods, TMS=1,1,1,1,1,0, TDI=0. `rsp_valid` after 1+240+1 cycles; `rsp_data`=0.
- IR scan, `cmd_data`=0xA → 10 periods. TMS=1,1,0,0,0,0,0,1,1,0. TDI on the shift bits = 0,1,0,1.
- DR len 32, TDO from a bench shifter loaded with 0xA5C30F96 (advances on TCK fall) → `rsp_data`=0xA5C30F96. TCK count = 37.
- DR len 4, `cmd_data`=0xB, TDO = 1-stage bypass model (capture 0) → `rsp_data`=0x6.
- DR len 0 → TMS=1,0,1,1,0, `rsp_data`=0. `cmd_len`=40 behaves exactly like 32.
- Assert `jtag_rst` during shift bit 10 of a 32-bit DR → next cycle TCK=0 and TMS=1, no `rsp_valid`. A new RESET command is then accepted and completes normally.
